// File: rtl/face_report_tx_pkg.sv
// Shared types and constants for the face report transmitter.
// Record layout, FSM states and byte selection helper.
package face_report_tx_pkg;

  localparam int REC_BYTES = 16;
  localparam logic [7:0] NO_FACE_BYTE = 8'h00;

  typedef struct packed {
    logic [31:0] pyramid;
    logic [31:0] row;
    logic [31:0] col;
    logic [31:0] accum;
  } face_record_t;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    WAIT_CTS,
    SEND,
    GAP,
    SEND_NONE
  } tx_state_t;

  // Byte idx of a record: word idx/4, little-endian inside the word.
  function automatic logic [7:0] rec_byte(
    face_record_t r,
    logic [3:0]   idx
  );
    logic [31:0] w;
    case (idx[3:2])
      2'd0:    w = r.pyramid;
      2'd1:    w = r.row;
      2'd2:    w = r.col;
      default: w = r.accum;
    endcase
    return w[{idx[1:0], 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/face_report_tx_fifo.sv
// Record FIFO for the face report transmitter.
// Distributed-RAM store with a combinational head read.
module face_record_fifo
  import face_report_tx_pkg::*;
#(
  parameter int DEPTH = 100
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  face_record_t               din,
  output face_record_t               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  face_record_t mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage write; contents need no reset.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointers wrap modulo DEPTH; count tracks occupancy.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok)
        wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop_ok)
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/face_report_tx.sv
// Face detection report transmitter.
// Queues detections and streams them byte-wise to a UART.
module face_report_tx
  import face_report_tx_pkg::*;
#(
  parameter int DEPTH   = 100,
  parameter int MAX_GAP = 50
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       face_coords_ready,
  input  logic [3:0]                 pyramid_number,
  input  logic [1:0][31:0]           face_coords,
  input  logic [31:0]                accum,
  input  logic                       vj_pipeline_done,
  input  logic                       uart_cts,
  input  logic                       uart_data_sent,
  output logic [7:0]                 uart_data_tx,
  output logic                       send_uart_data,
  output logic                       busy,
  output logic                       overflow,
  output logic [$clog2(DEPTH+1)-1:0] record_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int GW = (MAX_GAP > 1) ? $clog2(MAX_GAP + 1) : 1;

  tx_state_t    state, state_nx;
  logic [3:0]   byte_idx, byte_nx;
  logic [CW-1:0] frame_records, frame_nx;
  logic [GW-1:0] gap_cnt, gap_nx;
  logic         send_nx;
  logic         pop;
  logic         fifo_full;
  logic         fifo_empty;
  face_record_t new_rec;
  face_record_t head;

  assign new_rec = '{
    pyramid: {28'd0, pyramid_number},
    row:     face_coords[1],
    col:     face_coords[0],
    accum:   accum
  };

  face_record_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (face_coords_ready),
    .pop     (pop),
    .din     (new_rec),
    .dout    (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (record_count)
  );

  assign busy = (state != IDLE);

  // Next-state, byte sequencing and request decode.
  always_comb begin
    state_nx = state;
    byte_nx  = byte_idx;
    frame_nx = frame_records;
    gap_nx   = gap_cnt;
    pop      = 1'b0;
    send_nx  = 1'b0;
    unique case (state)
      IDLE: begin
        if (vj_pipeline_done)
          state_nx = fifo_empty ? SEND_NONE : LATCH;
      end
      LATCH: begin
        frame_nx = record_count;
        byte_nx  = '0;
        state_nx = WAIT_CTS;
      end
      WAIT_CTS: begin
        if (uart_cts) begin
          state_nx = SEND;
          send_nx  = 1'b1;
        end
      end
      SEND: begin
        if (uart_data_sent) begin
          state_nx = GAP;
          gap_nx   = '0;
        end else begin
          send_nx = 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt == GW'(MAX_GAP - 1)) begin
          if (byte_idx != 4'(REC_BYTES - 1)) begin
            byte_nx  = byte_idx + 1'b1;
            state_nx = WAIT_CTS;
          end else begin
            pop      = 1'b1;
            frame_nx = frame_records - 1'b1;
            byte_nx  = '0;
            state_nx = (frame_records > CW'(1)) ? WAIT_CTS : IDLE;
          end
        end else begin
          gap_nx = gap_cnt + 1'b1;
        end
      end
      SEND_NONE: begin
        if (send_uart_data && uart_data_sent)
          state_nx = IDLE;
        else
          send_nx = send_uart_data | uart_cts;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, counters and registered UART request/data.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      byte_idx       <= '0;
      frame_records  <= '0;
      gap_cnt        <= '0;
      send_uart_data <= 1'b0;
      uart_data_tx   <= 8'd0;
      overflow       <= 1'b0;
    end else begin
      state          <= state_nx;
      byte_idx       <= byte_nx;
      frame_records  <= frame_nx;
      gap_cnt        <= gap_nx;
      send_uart_data <= send_nx;
      if (state_nx == SEND)
        uart_data_tx <= rec_byte(head, byte_idx);
      else if (state_nx == SEND_NONE && send_nx)
        uart_data_tx <= NO_FACE_BYTE;
      if (face_coords_ready && fifo_full)
        overflow <= 1'b1;
    end
  end

endmodule

// File: doc/face_report_tx.md
FACE_REPORT_TX -- requirements
Module: face_report_tx

Interface
REQ-001 Parameter DEPTH, default 100: record capacity of the queue, in records.
REQ-002 Parameter MAX_GAP, default 50: minimum idle cycles between bytes.
REQ-003 Port clock, input, 1: sole clock; all state updates on its rising edge.
REQ-004 Port reset_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port face_coords_ready, input, 1: one-cycle pulse; the current detection fields are valid.
REQ-006 Port pyramid_number, input, 4: scale index of the detection.
REQ-007 Port face_coords, input, 2x32: [1] is row, [0] is column of the detection.
REQ-008 Port accum, input, 32: classifier score of the detection.
REQ-009 Port vj_pipeline_done, input, 1: one-cycle pulse; the frame has finished.
REQ-010 Port uart_cts, input, 1: high when the laptop may receive.
REQ-011 Port uart_data_sent, input, 1: one-cycle pulse from uart_tcvr; the byte is complete.
REQ-012 Port uart_data_tx, output, 8: byte presented to uart_tcvr.
REQ-013 Port send_uart_data, output, 1: request to uart_tcvr to transmit uart_data_tx.
REQ-014 Port busy, output, 1: high in any state other than IDLE.
REQ-015 Port overflow, output, 1: sticky; a record was dropped because the queue was full.
REQ-016 Port record_count, output, clog2(DEPTH+1): current queue occupancy.

Function
REQ-017 A record SHALL be 16 bytes, sent little-endian per word in this order: {28'd0, pyramid_number}, face_coords[1], face_coords[0], accum.
REQ-018 Enqueue:
- A face_coords_ready pulse with record_count<DEPTH SHALL write one record and increment record_count on the next edge.
- With record_count==DEPTH, the record SHALL be dropped and overflow set.
- Enqueue SHALL be accepted in every state.
REQ-019 The FSM states SHALL be IDLE, LATCH, WAIT_CTS, SEND, GAP and SEND_NONE.
REQ-020 IDLE + vj_pipeline_done:
- record_count>0 SHALL go to LATCH.
- record_count==0 SHALL go to SEND_NONE.
- vj_pipeline_done in any other state SHALL be ignored.
REQ-021 LATCH SHALL capture frame_records=record_count and byte_idx=0, then go to WAIT_CTS.
- Records enqueued after LATCH SHALL stay queued for the next frame.
REQ-022 WAIT_CTS:
- uart_cts==1 SHALL go to SEND.
- Otherwise it SHALL hold with send_uart_data=0.
- uart_cts is sampled only here; a byte already in SEND completes regardless of uart_cts.
REQ-023 SEND:
- send_uart_data=1, with uart_data_tx equal to byte byte_idx of the head record and stable until uart_data_sent.
- On uart_data_sent it SHALL go to GAP.
REQ-024 GAP SHALL hold send_uart_data=0 for exactly MAX_GAP cycles, then advance:
- byte_idx<15: byte_idx+1, go to WAIT_CTS.
- byte_idx==15: pop the head record, decrement frame_records; go to WAIT_CTS with byte_idx=0 if frame_records>1, else go to IDLE.
REQ-025 SEND_NONE SHALL wait for uart_cts==1, then present 0x00 with send_uart_data=1 until uart_data_sent, then go to IDLE.
REQ-026 If a pop and an enqueue occur in the same cycle, record_count SHALL be unchanged and both operations SHALL take effect.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH.
REQ-028 send_uart_data SHALL be registered and never high for two consecutive bytes without an intervening low cycle.

Reset
REQ-029 On reset_n low, asynchronously:
- state=IDLE, pointers=0, record_count=0, frame_records=0, byte_idx=0.
- overflow=0, send_uart_data=0, uart_data_tx=8'd0, busy=0.
REQ-030 Reset asserted mid-byte SHALL abandon the transfer and discard all queued records.
REQ-031 Record storage contents SHALL NOT require reset.

Structure
REQ-032 The shared package SHALL hold:
- face_record_t, a packed 128-bit struct with fields pyramid, row, col, accum.
- tx_state_t, the state enum.
- The constants REC_BYTES=16 and NO_FACE_BYTE=8'h00.
REQ-033 The record store SHALL be the sub-module face_record_fifo, a synchronous FIFO with push/pop/full/empty/count.
- It SHALL be inferable as distributed RAM with a combinational head read.

Verification
REQ-034 Single record, no flow control:
- Stimulus: enqueue pyramid=3, row=0x12, col=0x34, accum=0x0102_0304; done; uart_cts=1.
- Response: bytes 03 00 00 00 12 00 00 00 34 00 00 00 04 03 02 01, then IDLE.
REQ-035 Empty frame:
- Stimulus: done with record_count=0.
- Response: exactly one byte 0x00, then busy=0.
REQ-036 Flow control:
- Stimulus: uart_cts=0 after byte 5.
- Response: no send_uart_data until uart_cts=1; byte 6 correct; no bytes lost or duplicated.
REQ-037 Overflow with DEPTH=4:
- Stimulus: enqueue 5 records.
- Response: overflow=1, record_count=4, exactly 64 bytes sent in order.
REQ-038 Enqueue during drain:
- Stimulus: 2 records latched; a third enqueued mid-transfer.
- Response: 32 bytes sent; record_count=1 in IDLE; the next done sends the third record.
REQ-039 Reset mid-transfer:
- Stimulus: assert reset_n=0 during SEND.
- Response: send_uart_data=0 immediately, record_count=0; the next done yields 0x00.
